// File: rtl/spi_motor_responder_if.sv
// SPI pin bundle between the myoControl master and the motor-board responder.
interface spi_motor_responder_if;
    logic sclk;
    logic mosi;
    logic ss_n;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output mosi, output ss_n, input miso, input miso_oe);
    modport slave  (input sclk, input mosi, input ss_n, output miso, output miso_oe);
endinterface

// File: rtl/spi_motor_responder.sv
// Motor-board end of the 12-word myoControl SPI link: oversampled mode-0 slave that
// commits the command words atomically and returns a snapshot of the status words.
module spi_motor_responder #(
    parameter int unsigned WORDS_PER_FRAME = 12,
    parameter logic [15:0] SOF_WORD        = 16'h8000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    spi_motor_responder_if.slave spi,
    input  logic [31:0]          position_i,
    input  logic [15:0]          velocity_i,
    input  logic [15:0]          current_i,
    input  logic [15:0]          displacement_i,
    input  logic [15:0]          sensor1_i,
    input  logic [15:0]          sensor2_i,
    output logic [15:0]          pwm_ref_o,
    output logic [15:0]          control_flags1_o,
    output logic [15:0]          control_flags2_o,
    output logic                 frame_valid_o,
    output logic                 frame_error_o,
    output logic [3:0]           word_count_o
);
    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {S_WAIT_IDLE, S_IDLE, S_ACTIVE, S_DONE, S_ERROR} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [3:0]             word_cnt_q, word_cnt_d;
    logic [14:0]            rx_shift_q, rx_shift_d;
    logic [15:0]            tx_shift_q, tx_shift_d;
    logic                   load_pend_q, load_pend_d;
    logic [14:0]            slot1_q, slot1_d;
    logic [15:0]            slot2_q, slot2_d, slot3_q, slot3_d;
    logic [31:0]            snap_pos_q, snap_pos_d;
    logic [4:0][15:0]       snap_q, snap_d;
    logic [15:0]            pwm_ref_q, pwm_ref_d, flags1_q, flags1_d, flags2_q, flags2_d;
    logic                   frame_valid_q, frame_error_q;
    logic                   commit, abort;
    logic [15:0]            tx_load_word;

    wire sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    wire mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    wire ss_s      = ss_sync_q[SYNC_STAGES-1];
    wire sclk_rise = sclk_s & ~sclk_prev_q;
    wire sclk_fall = ~sclk_s & sclk_prev_q;
    wire ss_rise   = ss_s & ~ss_prev_q;
    wire ss_fall   = ~ss_s & ss_prev_q;
    wire [15:0] rx_word   = {rx_shift_q, mosi_s};
    wire        word_done = (state_q == S_ACTIVE) && sclk_rise && (bit_cnt_q == 4'd15);
    wire        miso_oe   = (state_q != S_WAIT_IDLE) && !ss_s;

    // ss_n synchronizer resets to "selected" so a reset mid-frame cannot fake an idle gap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss_n};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    always_comb begin
        tx_load_word = '0;
        case (word_cnt_q)
            4'd5:    tx_load_word = snap_pos_q[31:16];
            4'd6:    tx_load_word = snap_pos_q[15:0];
            4'd7:    tx_load_word = snap_q[0];
            4'd8:    tx_load_word = snap_q[1];
            4'd9:    tx_load_word = snap_q[2];
            4'd10:   tx_load_word = snap_q[3];
            4'd11:   tx_load_word = snap_q[4];
            default: tx_load_word = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        load_pend_d = load_pend_q;
        slot1_d     = slot1_q;
        slot2_d     = slot2_q;
        slot3_d     = slot3_q;
        snap_pos_d  = snap_pos_q;
        snap_d      = snap_q;
        commit      = 1'b0;
        abort       = 1'b0;
        case (state_q)
            S_WAIT_IDLE: if (ss_s) state_d = S_IDLE;
            S_IDLE: begin
                if (ss_fall) begin
                    snap_pos_d  = position_i;
                    snap_d      = {sensor2_i, sensor1_i, displacement_i, current_i, velocity_i};
                    bit_cnt_d   = '0;
                    word_cnt_d  = '0;
                    rx_shift_d  = '0;
                    tx_shift_d  = '0;
                    load_pend_d = 1'b0;
                    state_d     = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (sclk_rise) begin
                    rx_shift_d = rx_word[14:0];
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end
                // The next slot is loaded on the falling edge after a word completes.
                if (sclk_fall) begin
                    if (load_pend_q) begin
                        tx_shift_d  = tx_load_word;
                        load_pend_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[14:0], 1'b0};
                    end
                end
                if (word_done) begin
                    word_cnt_d  = word_cnt_q + 4'd1;
                    load_pend_d = 1'b1;
                    case (word_cnt_q)
                        4'd1:    slot1_d = rx_word[14:0];
                        4'd2:    slot2_d = rx_word;
                        4'd3:    slot3_d = rx_word;
                        default: ;
                    endcase
                    if (word_cnt_q == 4'd0 && rx_word != SOF_WORD) state_d = S_ERROR;
                    else if (word_cnt_q == LAST_WORD)              state_d = S_DONE;
                end
                if (ss_rise) begin
                    state_d = S_IDLE;
                    if (word_done && word_cnt_q == LAST_WORD) commit = 1'b1;
                    else                                      abort  = 1'b1;
                end
            end
            S_DONE: begin
                if (ss_rise) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else if (sclk_rise) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                if (ss_rise) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_WAIT_IDLE;
        endcase
        if (state_d == S_IDLE && state_q != S_IDLE) tx_shift_d = '0;
    end

    assign pwm_ref_d = commit ? {slot1_q[14], slot1_q} : pwm_ref_q;
    assign flags1_d  = commit ? slot2_q : flags1_q;
    assign flags2_d  = commit ? slot3_q : flags2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_WAIT_IDLE;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            load_pend_q   <= 1'b0;
            slot1_q       <= '0;
            slot2_q       <= '0;
            slot3_q       <= '0;
            snap_pos_q    <= '0;
            snap_q        <= '0;
            pwm_ref_q     <= '0;
            flags1_q      <= '0;
            flags2_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            load_pend_q   <= load_pend_d;
            slot1_q       <= slot1_d;
            slot2_q       <= slot2_d;
            slot3_q       <= slot3_d;
            snap_pos_q    <= snap_pos_d;
            snap_q        <= snap_d;
            pwm_ref_q     <= pwm_ref_d;
            flags1_q      <= flags1_d;
            flags2_q      <= flags2_d;
            frame_valid_q <= commit;
            frame_error_q <= abort;
        end
    end

    assign spi.miso_oe      = miso_oe;
    assign spi.miso         = miso_oe && (state_q != S_ERROR) && tx_shift_q[15];
    assign pwm_ref_o        = pwm_ref_q;
    assign control_flags1_o = flags1_q;
    assign control_flags2_o = flags2_q;
    assign frame_valid_o    = frame_valid_q;
    assign frame_error_o    = frame_error_q;
    assign word_count_o     = word_cnt_q;
endmodule

// File: tb/tb_spi_motor_responder.sv
// Bench for spi_motor_responder: SPI master driving directed and random frames,
// checked against a frame-level model of committed outputs and returned slots.
`timescale 1ns/1ps
module tb_spi_motor_responder;
    localparam int K_NORMAL = 0, K_SHORT = 1, K_OVER = 2, K_SIMUL = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    spi_motor_responder_if bus ();
    logic [31:0] position_i;
    logic [15:0] velocity_i, current_i, displacement_i, sensor1_i, sensor2_i;
    logic [15:0] pwm_ref_o, control_flags1_o, control_flags2_o;
    logic        frame_valid_o, frame_error_o;
    logic [3:0]  word_count_o;

    spi_motor_responder dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .spi              (bus),
        .position_i       (position_i),
        .velocity_i       (velocity_i),
        .current_i        (current_i),
        .displacement_i   (displacement_i),
        .sensor1_i        (sensor1_i),
        .sensor2_i        (sensor2_i),
        .pwm_ref_o        (pwm_ref_o),
        .control_flags1_o (control_flags1_o),
        .control_flags2_o (control_flags2_o),
        .frame_valid_o    (frame_valid_o),
        .frame_error_o    (frame_error_o),
        .word_count_o     (word_count_o)
    );

    int vectors = 0;
    int miscompares = 0;
    int valid_seen = 0;
    int error_seen = 0;
    bit settled = 1'b0;
    logic [15:0] exp_pwm = '0, exp_f1 = '0, exp_f2 = '0;
    logic [15:0] mw [12];
    logic [15:0] last_rx [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 15-bit two's complement field widened to 16 bits.
    function automatic logic [15:0] pwm_model(input logic [15:0] w);
        logic [15:0] m;
        m = w & 16'h7FFF;
        if (m >= 16'h4000) m = m + 16'h8000;
        return m;
    endfunction

    always @(negedge clock) begin
        if (settled) begin
            check("pwm_ref", {16'h0, pwm_ref_o}, {16'h0, exp_pwm});
            check("control_flags1", {16'h0, control_flags1_o}, {16'h0, exp_f1});
            check("control_flags2", {16'h0, control_flags2_o}, {16'h0, exp_f2});
        end
        check("pulse_overlap", {31'h0, frame_valid_o & frame_error_o}, 32'h0);
        check("miso_when_disabled", {31'h0, bus.miso & ~bus.miso_oe}, 32'h0);
        if (frame_valid_o) valid_seen++;
        if (frame_error_o) error_seen++;
    end

    task automatic set_words(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        mw[0] = w0; mw[1] = w1; mw[2] = w2; mw[3] = w3;
        for (int i = 4; i < 12; i++) mw[i] = 16'h0000;
    endtask

    task automatic rand_status();
        position_i     = $urandom;
        velocity_i     = 16'($urandom);
        current_i      = 16'($urandom);
        displacement_i = 16'($urandom);
        sensor1_i      = 16'($urandom);
        sensor2_i      = 16'($urandom);
    endtask

    task automatic half_wait();
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic run_frame(input int kind, input int nwords, input int reset_word, input bit pos_change);
        logic [15:0] slot_exp [12];
        logic [15:0] got;
        int v0, e0, n;
        bit sof_ok, did_reset, commits, errs, oe_all, oe_any;
        v0 = valid_seen;
        e0 = error_seen;
        sof_ok = (mw[0] == 16'h8000);
        did_reset = 1'b0;
        n = (kind == K_SHORT) ? nwords : 12;
        for (int s = 0; s < 12; s++) slot_exp[s] = 16'h0000;
        if (sof_ok) begin
            slot_exp[5]  = position_i[31:16];
            slot_exp[6]  = position_i[15:0];
            slot_exp[7]  = velocity_i;
            slot_exp[8]  = current_i;
            slot_exp[9]  = displacement_i;
            slot_exp[10] = sensor1_i;
            slot_exp[11] = sensor2_i;
        end
        bus.sclk = 1'b0;
        bus.ss_n = 1'b0;
        for (int w = 0; w < n; w++) begin
            got = '0;
            oe_all = 1'b1;
            oe_any = 1'b0;
            for (int b = 15; b >= 0; b--) begin
                bus.mosi = mw[w][b];
                half_wait();
                got[b] = bus.miso;
                oe_all = oe_all & bus.miso_oe;
                oe_any = oe_any | bus.miso_oe;
                if (w == reset_word && b == 8) begin
                    settled = 1'b0;
                    reset_n = 1'b0;
                    exp_pwm = '0; exp_f1 = '0; exp_f2 = '0;
                    did_reset = 1'b1;
                    repeat (3) @(posedge clock);
                    #1;
                    reset_n = 1'b1;
                    settled = 1'b1;
                end
                bus.sclk = 1'b1;
                if (kind == K_SIMUL && w == n - 1 && b == 0) begin
                    settled = 1'b0;
                    bus.ss_n = 1'b1;
                end
                half_wait();
                bus.sclk = 1'b0;
            end
            last_rx[w] = got;
            if (!did_reset) begin
                check($sformatf("miso_slot%0d", w), {16'h0, got}, {16'h0, slot_exp[w]});
                check($sformatf("miso_oe_slot%0d", w), {31'h0, oe_all}, 32'h1);
            end else if (w > reset_word) begin
                check($sformatf("miso_after_reset_slot%0d", w), {16'h0, got}, 32'h0);
                check($sformatf("oe_after_reset_slot%0d", w), {31'h0, oe_any}, 32'h0);
            end
            if (pos_change && w == 5) position_i = $urandom;
        end
        if (kind == K_OVER) begin
            bus.mosi = 1'($urandom);
            half_wait();
            bus.sclk = 1'b1;
            half_wait();
            bus.sclk = 1'b0;
        end
        half_wait();
        settled = 1'b0;
        bus.ss_n = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        commits = !did_reset && sof_ok && (kind == K_NORMAL || kind == K_SIMUL);
        errs = !did_reset && !commits;
        if (commits) begin
            exp_pwm = pwm_model(mw[1]);
            exp_f1  = mw[2];
            exp_f2  = mw[3];
        end
        check("frame_valid_pulses", valid_seen - v0, {31'h0, commits});
        check("frame_error_pulses", error_seen - e0, {31'h0, errs});
        if (!did_reset && sof_ok) check("word_count", {28'h0, word_count_o}, n);
        settled = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        int kind;
        bus.sclk = 1'b0; bus.mosi = 1'b0; bus.ss_n = 1'b1;
        position_i = '0; velocity_i = '0; current_i = '0;
        displacement_i = '0; sensor1_i = '0; sensor2_i = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_pwm_ref", {16'h0, pwm_ref_o}, 32'h0);
        check("reset_flags1", {16'h0, control_flags1_o}, 32'h0);
        check("reset_flags2", {16'h0, control_flags2_o}, 32'h0);
        check("reset_pulses", {30'h0, frame_valid_o, frame_error_o}, 32'h0);
        check("reset_word_count", {28'h0, word_count_o}, 32'h0);
        check("reset_miso", {30'h0, bus.miso, bus.miso_oe}, 32'h0);
        reset_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        settled = 1'b1;

        // Nominal frame with hand-derived expectations.
        rand_status();
        position_i = 32'h00010002;
        velocity_i = 16'hFFF0;
        set_words(16'h8000, 16'h1234, 16'h00A5, 16'h5A00);
        run_frame(K_NORMAL, 12, -1, 1'b0);
        check("pin_pwm_1234", {16'h0, pwm_ref_o}, 32'h1234);
        check("pin_flags1", {16'h0, control_flags1_o}, 32'h00A5);
        check("pin_flags2", {16'h0, control_flags2_o}, 32'h5A00);
        check("pin_slot5", {16'h0, last_rx[5]}, 32'h0001);
        check("pin_slot6", {16'h0, last_rx[6]}, 32'h0002);
        check("pin_slot7", {16'h0, last_rx[7]}, 32'hFFF0);

        mw[1] = 16'h7FFF;
        run_frame(K_NORMAL, 12, -1, 1'b0);
        check("pin_pwm_neg1", {16'h0, pwm_ref_o}, 32'hFFFF);
        mw[1] = 16'h4000;
        run_frame(K_NORMAL, 12, -1, 1'b0);
        check("pin_pwm_c000", {16'h0, pwm_ref_o}, 32'hC000);

        // Bad SOF: nothing returned, outputs held.
        set_words(16'h0000, 16'h1234, 16'h00A5, 16'h5A00);
        run_frame(K_NORMAL, 12, -1, 1'b0);
        check("pin_badsof_pwm", {16'h0, pwm_ref_o}, 32'hC000);
        check("pin_badsof_slot7", {16'h0, last_rx[7]}, 32'h0000);

        set_words(16'h8000, 16'h0321, 16'h1111, 16'h2222);
        run_frame(K_SHORT, 7, -1, 1'b0);
        check("pin_short_pwm", {16'h0, pwm_ref_o}, 32'hC000);
        run_frame(K_NORMAL, 12, -1, 1'b0);
        check("pin_after_short_pwm", {16'h0, pwm_ref_o}, 32'h0321);

        position_i = 32'hDEADBEEF;
        run_frame(K_NORMAL, 12, -1, 1'b1);
        check("pin_snap_slot5", {16'h0, last_rx[5]}, 32'hDEAD);
        check("pin_snap_slot6", {16'h0, last_rx[6]}, 32'hBEEF);

        set_words(16'h8000, 16'h0042, 16'h0F0F, 16'hF0F0);
        run_frame(K_NORMAL, 12, 2, 1'b0);
        check("pin_reset_pwm", {16'h0, pwm_ref_o}, 32'h0000);
        run_frame(K_NORMAL, 12, -1, 1'b0);
        check("pin_after_reset_pwm", {16'h0, pwm_ref_o}, 32'h0042);

        mw[1] = 16'h1111;
        run_frame(K_OVER, 12, -1, 1'b0);
        check("pin_oversize_pwm", {16'h0, pwm_ref_o}, 32'h0042);
        mw[1] = 16'h2222;
        run_frame(K_SIMUL, 12, -1, 1'b0);
        check("pin_simul_pwm", {16'h0, pwm_ref_o}, 32'h2222);

        for (int f = 0; f < 8; f++) begin
            rand_status();
            for (int i = 0; i < 12; i++) mw[i] = 16'($urandom);
            mw[0] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h8000;
            kind = int'($urandom_range(0, 3));
            run_frame(kind, int'($urandom_range(1, 11)), -1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_motor_responder.md
Name: spi_motor_responder

Overview:
- SPI slave frame handler for the motor-board end of the 12-word myoControl motor link.
- Receives the command frame: start-of-frame, PWM reference, control flags 1, control flags 2, dummy.
- Returns the status words (position, velocity, current, displacement, sensor1, sensor2) in slots 5..11 of the same full-duplex frame.
- SPI pins are oversampled in the system clock domain. Command outputs update atomically once per valid frame.

Parameters:
- WORDS_PER_FRAME, 12: 16-bit words per frame.
- SOF_WORD, 16'h8000: required value of slot 0.
- SYNC_STAGES, 2: synchronizer flops on sclk, mosi and ss_n; minimum value 2.

Ports:
- clock  in  1  system clock; must be at least 8x the sclk frequency.
- reset_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock; mode 0 (CPOL=0, CPHA=0).
- mosi  in  1  master-out data, MSB first.
- ss_n  in  1  active-low select; held low for the whole frame.
- miso  out  1  slave-out data, MSB first.
- miso_oe  out  1  miso output enable; high while synchronized ss_n is low.
- position  in  32  signed status position.
- velocity, current, displacement, sensor1, sensor2  in  16 each  signed status words.
- pwm_ref  out  16  signed PWM reference; sign-extended from the 15-bit field.
- control_flags1  out  16  last valid control flags 1.
- control_flags2  out  16  last valid control flags 2.
- frame_valid  out  1  one-cycle pulse when a valid frame commits.
- frame_error  out  1  one-cycle pulse when a frame is aborted or malformed.
- word_count  out  4  words completed in the current frame, for debug.

Behaviour:
- Reset: pwm_ref, control_flags1, control_flags2, frame_valid, frame_error, word_count, miso and miso_oe all 0. Internal shift registers cleared. State goes to WAIT_IDLE.
- Synchronization:
  - sclk, mosi and ss_n each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk and ss_n.
  - All logic runs in the clock domain.
- States:
  - WAIT_IDLE: wait for synchronized ss_n high, then go to IDLE. Covers reset mid-frame: the frame in progress is discarded, never half-received.
  - IDLE, on ss_n falling edge: snapshot all status inputs, clear the bit and word counters, load the tx shifter with 0 (slot 0), go to ACTIVE.
  - ACTIVE:
    - Rising sclk: shift mosi into rx_shift.
    - Falling sclk: shift tx_shift left.
    - After the 16th rising edge the word is complete: word_count increments and the word is stored to its slot register.
    - The tx_shift load for the next slot happens on the following falling edge, so the MSB is valid before the next rising edge.
    - Slot 0 != SOF_WORD: go to ERROR.
    - word_count reaches WORDS_PER_FRAME: go to DONE.
    - ss_n rises early: frame_error pulse, go to IDLE.
  - DONE:
    - ss_n rises: commit and pulse frame_valid, go to IDLE.
    - Any further sclk rising edge before ss_n rises: go to ERROR (oversized frame).
  - ERROR: miso driven 0; on ss_n rise pulse frame_error, no commit, go to IDLE.
- TX slot map, from the snapshot (never live inputs):
  - slots 0..4: 0.
  - slot 5: position[31:16]; slot 6: position[15:0].
  - slot 7: velocity; slot 8: current; slot 9: displacement.
  - slot 10: sensor1; slot 11: sensor2.
- miso output:
  - miso = tx_shift[15] when miso_oe is 1, else 0.
- RX slot map:
  - slot 1 bits [14:0] form pwm_ref; bit 15 is ignored, since the master clears it.
  - pwm_ref = {slot1[14], slot1[14:0]}.
  - slot 2: control_flags1; slot 3: control_flags2.
  - slot 4 and slots 5..11: discarded.
- Commit:
  - pwm_ref and both flag outputs load in the same cycle that frame_valid is high.
  - That cycle is one cycle after the synchronized ss_n rise is detected.
  - Outputs hold their value on error.
- Simultaneous events:
  - ss_n rise in the same cycle as the 16th rising edge of word 12: treat the word as completed first, then commit (valid).
  - ss_n fall in the same cycle as a commit pulse: the new frame starts; the commit still completes.
- frame_valid and frame_error are never high in the same cycle.

Test Plan:
- Nominal frame:
  - Stimulus: sclk = clock/10; master sends 8000, 1234, 00A5, 5A00, 0000, then 7x0000; position=32'h00010002, velocity=16'hFFF0.
  - Response: miso slots 5..7 = 0001, 0002, FFF0; pwm_ref=1234; flags 00A5/5A00; one frame_valid pulse.
- Negative PWM:
  - Stimulus: slot 1 = 7FFF.
  - Response: pwm_ref=FFFF.
  - Stimulus: slot 1 = 4000.
  - Response: pwm_ref=C000.
- Bad SOF:
  - Stimulus: slot 0 = 0000, remainder nominal.
  - Response: miso 0 for the whole frame; frame_error pulse; outputs unchanged.
- Short frame:
  - Stimulus: ss_n rises after 7 words.
  - Response: frame_error pulse, no commit.
  - Stimulus: the next full frame.
  - Response: commits normally.
- Snapshot consistency:
  - Stimulus: change position mid-frame after slot 5.
  - Response: slot 6 still carries the low half of the value snapshotted at the ss_n fall.
- Reset mid-frame:
  - Stimulus: assert reset_n low during word 3 with ss_n still low; release; the master finishes the frame.
  - Response: outputs remain 0 and no pulses until ss_n goes high; the next frame commits.
